// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: host write port plus transmitter launch handshake
interface uart_tx_feeder_if #(parameter int ADDR_W = 4);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              flush;
  logic              clr_ovf;
  logic              busy;
  logic              transmit;
  logic [7:0]        TX_DATA;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  modport master (
    output wr_en, wr_data, flush, clr_ovf, busy,
    input  transmit, TX_DATA, full, empty, count, overflow
  );
  modport slave (
    input  wr_en, wr_data, flush, clr_ovf, busy,
    output transmit, TX_DATA, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that launches one byte at a time into a UART transmitter
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_feeder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t            r_state, w_next;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [ADDR_W:0]   r_count, w_count;
  logic              r_full, r_empty, r_ovf;
  logic [7:0]        r_tx_data;
  logic              w_wr, w_rd;
  // a write is judged against the pre-cycle full flag; flush overrides both write and pop
  assign w_wr    = bus.wr_en && !r_full && !bus.flush;
  assign w_rd    = r_state == IDLE && !r_empty && !bus.flush;
  assign w_count = bus.flush ? '0 : r_count + (ADDR_W+1)'(w_wr) - (ADDR_W+1)'(w_rd);
  assign bus.TX_DATA  = r_tx_data;
  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;
  // launch state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  // busy high in REQ is acceptance; busy low in WAIT ends the frame
  always_comb
    w_next = r_state == IDLE ? (w_rd ? REQ : IDLE) :
             r_state == REQ  ? (bus.busy ? WAIT : REQ) :
                               (bus.busy ? WAIT : IDLE);
  // launch request is purely a function of state so reset drops it at once
  always_comb
    bus.transmit = r_state == REQ;
  // storage array, contents need no reset
  always_ff @(posedge CLK)
    if (w_wr) r_mem[r_wr_ptr] <= bus.wr_data;
  // pointers, occupancy flags, sticky overflow and the launched byte
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_rd_ptr  <= bus.flush ? '0 : w_rd ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;
      r_wr_ptr  <= bus.flush ? '0 : w_wr ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
      r_count   <= w_count;
      r_full    <= w_count == (ADDR_W+1)'(DEPTH);
      r_empty   <= w_count == '0;
      r_ovf     <= (bus.wr_en && r_full) || (r_ovf && !bus.clr_ovf);
      r_tx_data <= w_rd ? r_mem[r_rd_ptr] : r_tx_data;
    end
endmodule
